// File: rtl/instr_fetch.sv
// Instruction fetch front-end: PC sequencing, single-outstanding word reads, buffered instruction stream.
// Latency: MemAck in cycle N -> InstValid in N+1; one idle bubble between fetches.
// Backpressure: InstReady low fills the buffer, then new requests stall until an entry frees.
module fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushDat,
    input  logic             pop,
    output logic             notEmpty,
    output logic             full,
    output logic [WIDTH-1:0] headDat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;

    assign notEmpty = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign headDat  = mem[rdPtr];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wrPtr] <= pushDat;
        end
    end
endmodule

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 2
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        En,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemRdata,
    output logic        InstValid,
    output logic [31:0] DataInst,
    output logic [31:0] InstPc,
    input  logic        InstReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPc
);
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t      state;
    logic [31:0] fetchPc;
    logic [63:0] headDat;
    logic        bufFull;
    logic        bufNotEmpty;
    logic        pushEn;
    logic        popEn;

    // Redirect wins over any same-cycle push or pop.
    assign pushEn = (state == REQ) && MemAck && !Redirect;
    assign popEn  = bufNotEmpty && InstReady && !Redirect;

    fifo #(.WIDTH(64), .DEPTH(DEPTH)) instBuf (
        .clk      (Clk),
        .rstN     (RstN),
        .flush    (Redirect),
        .push     (pushEn),
        .pushDat  ({fetchPc, MemRdata}),
        .pop      (popEn),
        .notEmpty (bufNotEmpty),
        .full     (bufFull),
        .headDat  (headDat)
    );

    assign InstValid          = bufNotEmpty;
    assign {InstPc, DataInst} = headDat;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state   <= IDLE;
            MemReq  <= 1'b0;
            MemAddr <= RESET_PC;
            fetchPc <= RESET_PC;
        end else if (Redirect) begin
            fetchPc <= RedirectPc & ~32'h3;
            case (state)
                IDLE: state <= IDLE;
                REQ, DISCARD: begin
                    // An outstanding read must still be retired; its data is dropped.
                    if (MemAck) begin
                        state  <= IDLE;
                        MemReq <= 1'b0;
                    end else begin
                        state <= DISCARD;
                    end
                end
                default: begin
                    state  <= IDLE;
                    MemReq <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (En && !bufFull) begin
                        state   <= REQ;
                        MemReq  <= 1'b1;
                        MemAddr <= fetchPc;
                    end
                end
                REQ: begin
                    if (MemAck) begin
                        state   <= IDLE;
                        MemReq  <= 1'b0;
                        fetchPc <= fetchPc + 32'd4;
                    end
                end
                DISCARD: begin
                    if (MemAck) begin
                        state  <= IDLE;
                        MemReq <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    MemReq <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder, stream model (expected next PC), directed scenarios.
module tb_instr_fetch;
    localparam logic [31:0] K = 32'hA5A50000;

    logic        Clk;
    logic        RstN;
    logic        En;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRdata;
    logic        InstValid;
    logic [31:0] DataInst;
    logic [31:0] InstPc;
    logic        InstReady;
    logic        Redirect;
    logic [31:0] RedirectPc;

    instr_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .Clk        (Clk),
        .RstN       (RstN),
        .En         (En),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemAck     (MemAck),
        .MemRdata   (MemRdata),
        .InstValid  (InstValid),
        .DataInst   (DataInst),
        .InstPc     (InstPc),
        .InstReady  (InstReady),
        .Redirect   (Redirect),
        .RedirectPc (RedirectPc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          nChecks = 0;
    int          nPass = 0;
    bit          autoAck = 0;
    int          manualCnt = 0;
    int          manualDone = 0;
    logic [31:0] manualData = 32'h0;
    int          waitCnt = 0;
    int          reqRises = 0;
    int          reqMark = 0;
    logic [31:0] lastReqAddr = 32'h0;
    logic [31:0] hsLog[$];
    logic [31:0] expPc = 32'h0;
    bit          prevValid = 0;
    bit          prevRedirect = 0;
    bit          prevAck = 0;
    bit          prevReq = 0;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Memory: acks one cycle after a request is seen, or returns a bench-supplied word on demand.
    initial begin
        MemAck = 1'b0;
        MemRdata = 32'h0;
        forever begin
            @(posedge Clk);
            #2;
            if (MemAck) begin
                MemAck = 1'b0;
                waitCnt = 0;
            end else if (manualDone != manualCnt) begin
                MemAck = 1'b1;
                MemRdata = manualData;
                manualDone++;
            end else if (autoAck && MemReq) begin
                waitCnt++;
                if (waitCnt >= 1) begin
                    MemAck = 1'b1;
                    MemRdata = MemAddr ^ K;
                    waitCnt = 0;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Model: the head must always be the next PC of the current stream; a redirect restarts the stream.
    always @(negedge Clk) begin
        if (!RstN) begin
            checkEq("rst_valid", 32'(InstValid), 32'd0);
            checkEq("rst_memreq", 32'(MemReq), 32'd0);
            checkEq("rst_memaddr", MemAddr, 32'h0);
            expPc = 32'h0;
            prevValid = 0;
            prevRedirect = 0;
            prevAck = 0;
            prevReq = 0;
        end else begin
            if (prevRedirect) checkEq("flush_valid", 32'(InstValid), 32'd0);
            if (InstValid && !prevValid) checkEq("push_latency_ack_prev", 32'(prevAck), 32'd1);
            if (InstValid) begin
                checkEq("head_pc", InstPc, expPc);
                checkEq("head_data", DataInst, expPc ^ K);
            end
            if (MemReq) checkEq("addr_align", 32'(MemAddr[1:0]), 32'd0);
            if (MemReq && !prevReq) begin
                reqRises++;
                lastReqAddr = MemAddr;
            end
            if (Redirect) expPc = RedirectPc & ~32'h3;
            else if (InstValid && InstReady) begin
                hsLog.push_back(InstPc);
                expPc = expPc + 32'd4;
            end
            prevValid = InstValid;
            prevRedirect = Redirect;
            prevAck = MemAck;
            prevReq = MemReq;
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        cyc();
        RstN = 1'b0;
        cyc();
        RstN = 1'b1;
        hsLog.delete();
        reqMark = reqRises;
    endtask

    task automatic waitReqRise(input logic [31:0] expAddr, input string name);
        int i;
        i = 0;
        while (reqRises == reqMark && i < 200) begin
            @(negedge Clk);
            #1;
            i++;
        end
        checkEq({name, "_seen"}, 32'(reqRises != reqMark), 32'd1);
        checkEq(name, lastReqAddr, expAddr);
        reqMark = reqRises;
    endtask

    task automatic waitHs(input int n, input string name);
        int i;
        i = 0;
        while (hsLog.size() < n && i < 300) begin
            @(negedge Clk);
            #1;
            i++;
        end
        checkEq({name, "_seen"}, 32'(hsLog.size() >= n), 32'd1);
    endtask

    initial begin
        RstN = 1'b0;
        En = 1'b0;
        InstReady = 1'b0;
        Redirect = 1'b0;
        RedirectPc = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        checkEq("reset_memreq", 32'(MemReq), 32'd0);
        checkEq("reset_memaddr", MemAddr, 32'h0);
        checkEq("reset_valid", 32'(InstValid), 32'd0);
        checkEq("reset_datainst", DataInst, 32'h0);
        checkEq("reset_instpc", InstPc, 32'h0);
        RstN = 1'b1;

        // Streaming with a one-cycle memory
        En = 1'b1;
        InstReady = 1'b1;
        autoAck = 1;
        waitHs(4, "stream_hs");
        checkEq("stream_pc0", hsLog[0], 32'h0);
        checkEq("stream_pc1", hsLog[1], 32'h4);
        checkEq("stream_pc2", hsLog[2], 32'h8);
        checkEq("stream_pc3", hsLog[3], 32'hC);

        // Backpressure: buffer fills with two words, fetching stops
        En = 1'b0;
        InstReady = 1'b0;
        doReset();
        En = 1'b1;
        repeat (30) cyc();
        checkEq("bp_requests", 32'(reqRises - reqMark), 32'd2);
        checkEq("bp_memreq_low", 32'(MemReq), 32'd0);
        checkEq("bp_head_pc", InstPc, 32'h0);
        checkEq("bp_head_data", DataInst, 32'hA5A50000);
        repeat (5) cyc();
        checkEq("bp_head_stable", InstPc, 32'h0);
        reqMark = reqRises;
        InstReady = 1'b1;
        waitReqRise(32'h8, "bp_resume_addr");
        waitHs(2, "bp_hs");
        checkEq("bp_order0", hsLog[0], 32'h0);
        checkEq("bp_order1", hsLog[1], 32'h4);

        // Redirect while a request is in flight; ack arrives three cycles later
        En = 1'b0;
        autoAck = 0;
        doReset();
        En = 1'b1;
        waitReqRise(32'h0, "rif_first_addr");
        cyc();
        Redirect = 1'b1;
        RedirectPc = 32'h00000102;
        cyc();
        Redirect = 1'b0;
        hsLog.delete();
        repeat (2) cyc();
        checkEq("rif_discard_hold", 32'(MemReq), 32'd1);
        manualData = 32'hDEADBEEF;
        manualCnt++;
        autoAck = 1;
        waitReqRise(32'h100, "rif_next_addr");
        waitHs(1, "rif_hs");
        checkEq("rif_first_pc", hsLog[0], 32'h100);

        // Two redirects while discarding
        En = 1'b0;
        autoAck = 0;
        doReset();
        En = 1'b1;
        waitReqRise(32'h0, "dbl_first_addr");
        cyc();
        Redirect = 1'b1;
        RedirectPc = 32'h200;
        cyc();
        Redirect = 1'b0;
        cyc();
        Redirect = 1'b1;
        RedirectPc = 32'h300;
        cyc();
        Redirect = 1'b0;
        hsLog.delete();
        cyc();
        manualData = 32'hDEADBEEF;
        manualCnt++;
        autoAck = 1;
        waitReqRise(32'h300, "dbl_next_addr");
        waitHs(1, "dbl_hs");
        checkEq("dbl_first_pc", hsLog[0], 32'h300);

        // Redirect, MemAck and pop in one cycle
        En = 1'b0;
        InstReady = 1'b0;
        autoAck = 0;
        doReset();
        En = 1'b1;
        waitReqRise(32'h0, "sim_addr0");
        cyc();
        manualData = 32'h0 ^ K;
        manualCnt++;
        waitReqRise(32'h4, "sim_addr4");
        cyc();
        Redirect = 1'b1;
        RedirectPc = 32'h400;
        InstReady = 1'b1;
        manualData = 32'hDEADBEEF;
        manualCnt++;
        reqMark = reqRises;
        cyc();
        Redirect = 1'b0;
        hsLog.delete();
        autoAck = 1;
        @(negedge Clk);
        checkEq("sim_valid_after", 32'(InstValid), 32'd0);
        waitReqRise(32'h400, "sim_next_addr");
        waitHs(1, "sim_hs");
        checkEq("sim_first_pc", hsLog[0], 32'h400);

        // PC wrap from the top of the address space, then fetch disable
        En = 1'b0;
        doReset();
        Redirect = 1'b1;
        RedirectPc = 32'hFFFFFFFC;
        En = 1'b1;
        cyc();
        Redirect = 1'b0;
        hsLog.delete();
        reqMark = reqRises;
        waitReqRise(32'hFFFFFFFC, "wrap_addr");
        waitHs(2, "wrap_hs");
        checkEq("wrap_pc0", hsLog[0], 32'hFFFFFFFC);
        checkEq("wrap_pc1", hsLog[1], 32'h0);
        cyc();
        En = 1'b0;
        repeat (6) cyc();
        reqMark = reqRises;
        repeat (10) cyc();
        checkEq("en_off_requests", 32'(reqRises - reqMark), 32'd0);
        checkEq("en_off_memreq", 32'(MemReq), 32'd0);

        // Asynchronous reset during an outstanding request, then a stale ack
        autoAck = 0;
        En = 1'b1;
        reqMark = reqRises;
        waitReqRise(32'h8, "arst_req_addr");
        @(posedge Clk);
        #3;
        RstN = 1'b0;
        #1;
        checkEq("arst_memreq", 32'(MemReq), 32'd0);
        checkEq("arst_memaddr", MemAddr, 32'h0);
        checkEq("arst_valid", 32'(InstValid), 32'd0);
        checkEq("arst_instpc", InstPc, 32'h0);
        checkEq("arst_datainst", DataInst, 32'h0);
        En = 1'b0;
        cyc();
        RstN = 1'b1;
        hsLog.delete();
        manualData = 32'hDEADBEEF;
        manualCnt++;
        repeat (5) cyc();
        checkEq("stale_valid", 32'(InstValid), 32'd0);
        checkEq("stale_memreq", 32'(MemReq), 32'd0);
        reqMark = reqRises;
        En = 1'b1;
        autoAck = 1;
        waitReqRise(32'h0, "post_rst_addr");
        waitHs(1, "post_rst_hs");
        checkEq("post_rst_pc", hsLog[0], 32'h0);

        repeat (3) cyc();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
